// File: rtl/cube_pkg.sv
// Shared definitions for the sequential cube unit: FSM state encoding and
// the helper used to size the bit counter.
package cube_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CU   = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage : cube_pkg

// File: rtl/cube_seq_shift_add_step.sv
// One step of an LSB-first shift-add multiplier: conditional accumulate,
// then shift the multiplicand left and the multiplier right.
module shift_add_step #(
    parameter int W = 24,
    parameter int M = 8
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] mcand,
    input  logic [M-1:0] mplier,
    output logic [W-1:0] acc_nxt,
    output logic [W-1:0] mcand_nxt,
    output logic [M-1:0] mplier_nxt
);

    assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_nxt  = mcand << 1;
    assign mplier_nxt = mplier >> 1;

endmodule : shift_add_step

// File: rtl/cube_seq.sv
// Sequential cube unit: y = x^3 using one shared shift-add multiplier,
// first for x*x (SQ) and then for (x*x)*x (CU); latency is fixed at 2N cycles.
module cube_seq
    import cube_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x_b,
    output logic           busy,
    output logic           done,
    output logic [3*N-1:0] y_b
);

    localparam int W  = 3 * N;
    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, state_nxt;
    logic [N-1:0]  a, a_nxt;
    logic [N-1:0]  mplier, mplier_nxt;
    logic [W-1:0]  mcand, mcand_nxt;
    logic [W-1:0]  acc, acc_nxt;
    logic [W-1:0]  y_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    logic [W-1:0]  step_acc, step_mcand;
    logic [N-1:0]  step_mplier;

    // The upper N bits of the multiplicand stay zero throughout SQ, so the
    // full-width instance serves both phases.
    shift_add_step #(.W(W), .M(N)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (step_acc),
        .mcand_nxt  (step_mcand),
        .mplier_nxt (step_mplier)
    );

    assign busy = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nxt  = state;
        a_nxt      = a;
        mplier_nxt = mplier;
        mcand_nxt  = mcand;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        y_nxt      = y_b;
        done_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    a_nxt      = x_b;
                    mplier_nxt = x_b;
                    mcand_nxt  = W'(x_b);
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = SQ;
                end
            end
            SQ: begin
                acc_nxt    = step_acc;
                mcand_nxt  = step_mcand;
                mplier_nxt = step_mplier;
                cnt_nxt    = cnt + CW'(1);
                if (cnt == LAST) begin
                    // step_acc now holds x^2; restart the multiplier on it.
                    mplier_nxt = a;
                    mcand_nxt  = step_acc;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = CU;
                end
            end
            CU: begin
                acc_nxt    = step_acc;
                mcand_nxt  = step_mcand;
                mplier_nxt = step_mplier;
                cnt_nxt    = cnt + CW'(1);
                if (cnt == LAST) begin
                    y_nxt     = step_acc;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a      <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            y_b    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a      <= a_nxt;
            mplier <= mplier_nxt;
            mcand  <= mcand_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            y_b    <= y_nxt;
            done   <= done_nxt;
        end
    end

endmodule : cube_seq

// File: tb/tb_cube_seq.sv
// Self-checking bench for cube_seq: directed scenarios plus random operands
// compared against an arithmetic x^3 reference.
module tb_cube_seq;

    localparam int N = 8;
    localparam int LAT = 2 * N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   x_b;
    logic           busy;
    logic           done;
    logic [3*N-1:0] y_b;

    int checks   = 0;
    int failures = 0;

    cube_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_b   (x_b),
        .busy  (busy),
        .done  (done),
        .y_b   (y_b)
    );

    always #5 clk = ~clk;

    function automatic logic [3*N-1:0] cube_ref(input int x);
        longint v;
        v = longint'(x) * longint'(x) * longint'(x);
        return v[3*N-1:0];
    endfunction

    function automatic int isqrt_ref(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Runs one operation from idle; x_b is scrambled while busy.
    task automatic do_op(input logic [N-1:0] x, output logic [3*N-1:0] y,
                         output int bcyc, output int dpulses, output bit done_end);
        @(negedge clk);
        x_b   = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_b   = N'($urandom);
        bcyc    = 0;
        dpulses = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            if (done) dpulses++;
            @(negedge clk);
        end
        done_end = done;
        if (done) dpulses++;
        y = y_b;
        @(negedge clk);
        if (done) dpulses++;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b0;
        x_b   = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y_b !== '0) begin
            failures++;
            $display("FAIL reset_initial: busy=%b done=%b y_b=%0d, required 0 0 0", busy, done, y_b);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int xs[4] = '{5, 3, 1, 0};
        logic [3*N-1:0] y;
        int bc, dp;
        bit de;
        foreach (xs[i]) begin
            do_op(N'(xs[i]), y, bc, dp, de);
            checks++;
            if (y !== cube_ref(xs[i])) begin
                failures++;
                $display("FAIL basic_y x=%0d: y_b=%0d, required %0d", xs[i], y, cube_ref(xs[i]));
            end
            checks++;
            if (bc !== LAT) begin
                failures++;
                $display("FAIL basic_latency x=%0d: busy cycles=%0d, required %0d", xs[i], bc, LAT);
            end
            checks++;
            if (dp !== 1 || de !== 1'b1) begin
                failures++;
                $display("FAIL basic_done x=%0d: done pulses=%0d at_end=%b, required 1 1", xs[i], dp, de);
            end
        end
    endtask

    task automatic test_max;
        logic [3*N-1:0] y;
        int bc, dp;
        bit de;
        do_op(8'd255, y, bc, dp, de);
        checks++;
        if (y !== 24'hFD02FF) begin
            failures++;
            $display("FAIL max_operand: y_b=%h, required fd02ff", y);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        @(negedge clk);
        x_b   = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        x_b   = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Hold start high through completion; the completing edge must not accept.
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || y_b !== 24'd64) begin
            failures++;
            $display("FAIL busy_ignore_y: done=%b y_b=%0d, required 1 64", done, y_b);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL completion_no_accept: busy=%b, required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_start_accept: busy=%b, required 1", busy);
        end
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== LAT + 1 || y_b !== cube_ref(9)) begin
            failures++;
            $display("FAIL held_start_result: cycles=%0d y_b=%0d, required %0d %0d",
                     cyc, y_b, LAT + 1, cube_ref(9));
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [3*N-1:0] y;
        int bc, dp;
        bit de;
        @(negedge clk);
        x_b   = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y_b !== '0) begin
            failures++;
            $display("FAIL abort_clear: busy=%b done=%b y_b=%0d, required 0 0 0", busy, done, y_b);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(8'd2, y, bc, dp, de);
        checks++;
        if (y !== 24'd8 || bc !== LAT) begin
            failures++;
            $display("FAIL abort_recover: y_b=%0d cycles=%0d, required 8 %0d", y, bc, LAT);
        end
    endtask

    task automatic test_reset_idle;
        checks++;
        if (y_b === '0) begin
            failures++;
            $display("FAIL idle_hold: y_b=0, required nonzero held result");
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (y_b !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b y_b=%0d, required 0 0 0", busy, done, y_b);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_chain;
        int ins[5] = '{1, 2, 25, 9, 16};
        logic [3*N-1:0] y;
        int bc, dp;
        bit de;
        int r;
        foreach (ins[i]) begin
            r = isqrt_ref(ins[i]);
            do_op(N'(r), y, bc, dp, de);
            checks++;
            if (y !== cube_ref(r)) begin
                failures++;
                $display("FAIL chain in=%0d: y_b=%0d, required %0d", ins[i], y, cube_ref(r));
            end
        end
    endtask

    task automatic test_random;
        logic [3*N-1:0] y;
        int bc, dp;
        bit de;
        int x;
        for (int k = 0; k < 20; k++) begin
            x = int'($urandom_range(255, 0));
            do_op(N'(x), y, bc, dp, de);
            checks++;
            if (y !== cube_ref(x) || bc !== LAT || dp !== 1) begin
                failures++;
                $display("FAIL random x=%0d: y_b=%0d cycles=%0d pulses=%0d, required %0d %0d 1",
                         x, y, bc, dp, cube_ref(x), LAT);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_busy_ignore;
        test_abort;
        test_reset_idle;
        test_chain;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cube_seq
